// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one mem_controller between the fetch port and the load/store port,
// sequencing ISSUE/HOLD/WAIT/DONE with a bounded wait for ready.
module mem_arbiter #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_D_STREAK   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     if_req,
    input  logic [ADDRESS_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0]    if_rdata,
    output logic                     if_done,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [2:0]               d_func3,
    input  logic [ADDRESS_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0]    d_wdata,
    output logic [DATA_WIDTH-1:0]    d_rdata,
    output logic                     d_done,
    output logic                     err,
    output logic                     mem_read_En,
    output logic                     mem_write_En,
    output logic [2:0]               mem_func3,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_data_in,
    input  logic [DATA_WIDTH-1:0]    mem_data_out,
    input  logic                     mem_ready,
    output logic                     busy,
    output logic                     grant_d
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, ISSUE, HOLD, WAIT, DONE} state_t;
    state_t         state;
    logic [SW-1:0]  streak;
    logic [TW-1:0]  tcnt;
    logic           we_q;
    logic           pick_f;
    logic           timeout;
    // Fetch only wins when data is idle or data has used up its streak allowance.
    always_comb pick_f = if_req && (!d_req || streak == SW'(MAX_D_STREAK));
    always_comb timeout = tcnt == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state        <= IDLE;
            streak       <= '0;
            tcnt         <= '0;
            we_q         <= 1'b0;
            if_rdata     <= '0;
            if_done      <= 1'b0;
            d_rdata      <= '0;
            d_done       <= 1'b0;
            err          <= 1'b0;
            mem_read_En  <= 1'b0;
            mem_write_En <= 1'b0;
            mem_func3    <= '0;
            mem_address  <= '0;
            mem_data_in  <= '0;
            busy         <= 1'b0;
            grant_d      <= 1'b0;
        end else begin
            mem_read_En  <= 1'b0;
            mem_write_En <= 1'b0;
            if_done      <= 1'b0;
            d_done       <= 1'b0;
            err          <= 1'b0;
            if (!if_req)
                streak <= '0;
            else if (state == IDLE)
                streak <= pick_f ? '0 : (streak == SW'(MAX_D_STREAK) ? streak : streak + SW'(1));
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        state        <= ISSUE;
                        busy         <= 1'b1;
                        grant_d      <= !pick_f;
                        we_q         <= !pick_f && d_we;
                        mem_address  <= pick_f ? if_addr : d_addr;
                        mem_func3    <= pick_f ? 3'b010 : d_func3;
                        mem_data_in  <= pick_f ? '0 : d_wdata;
                        mem_read_En  <= pick_f || !d_we;
                        mem_write_En <= !pick_f && d_we;
                    end
                end
                ISSUE: state <= HOLD;
                HOLD:  state <= WAIT;
                WAIT: begin
                    if (mem_ready || timeout) begin
                        state   <= DONE;
                        tcnt    <= '0;
                        err     <= !mem_ready;
                        if_done <= !grant_d;
                        d_done  <= grant_d;
                        if (grant_d)
                            d_rdata <= (mem_ready && !we_q) ? mem_data_out : '0;
                        else
                            if_rdata <= mem_ready ? mem_data_out : '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    tcnt  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
